// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one single-port no-change BRAM between two requesters. At most one
// access is granted per cycle using round-robin priority. Reads are tracked
// through the BRAM read latency so each result goes back to the requester
// that issued it.
//
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   m0_req_* / m1_req_*         request channel (valid, we, addr, wdata) and
//                               ready (accepted this cycle)
//   m0_resp_* / m1_resp_*       read response: single-cycle valid plus data;
//                               data holds its last value when not valid
//   bram_addr/din/we/en         BRAM port A command
//   bram_regce, bram_rst        BRAM output-register enable and reset
//   bram_dout                   BRAM port A read data
module bram_port_arbiter #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req_valid,
    input  logic              m0_req_we,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    output logic              m0_req_ready,
    output logic              m0_resp_valid,
    output logic [DATA_W-1:0] m0_resp_rdata,

    input  logic              m1_req_valid,
    input  logic              m1_req_we,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    output logic              m1_req_ready,
    output logic              m1_resp_valid,
    output logic [DATA_W-1:0] m1_resp_rdata,

    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    output logic              bram_en,
    output logic              bram_regce,
    output logic              bram_rst,
    input  logic [DATA_W-1:0] bram_dout
);

    generate
        if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_read_lat
            $error("bram_port_arbiter: READ_LAT must be 1 or 2");
        end
    endgenerate

    logic                rr_ptr;
    logic                grant0;
    logic                grant1;
    logic                rd_accept;
    logic [READ_LAT-1:0] pipe_vld;
    logic [READ_LAT-1:0] pipe_pid;
    logic [DATA_W-1:0]   rdata0_q;
    logic [DATA_W-1:0]   rdata1_q;
    logic                resp0;
    logic                resp1;

    // Round-robin: a lone requester always wins; on contention rr_ptr decides.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            grant0 = m0_req_valid && (!m1_req_valid || (rr_ptr == 1'b0));
            grant1 = m1_req_valid && (!m0_req_valid || (rr_ptr == 1'b1));
        end
    end

    assign m0_req_ready = grant0;
    assign m1_req_ready = grant1;
    assign rd_accept    = (grant0 && !m0_req_we) || (grant1 && !m1_req_we);

    always_comb begin
        bram_addr = '0;
        bram_din  = '0;
        bram_we   = 1'b0;
        if (grant0) begin
            bram_addr = m0_req_addr;
            bram_din  = m0_req_wdata;
            bram_we   = m0_req_we;
        end else if (grant1) begin
            bram_addr = m1_req_addr;
            bram_din  = m1_req_wdata;
            bram_we   = m1_req_we;
        end
    end

    assign bram_en  = grant0 || grant1;
    assign bram_rst = rst;

    // The output register loads the cycle after the array read.
    generate
        if (READ_LAT == 2) begin : g_regce
            assign bram_regce = pipe_vld[0];
        end else begin : g_no_regce
            assign bram_regce = 1'b0;
        end
    endgenerate

    assign resp0 = pipe_vld[READ_LAT-1] && !pipe_pid[READ_LAT-1];
    assign resp1 = pipe_vld[READ_LAT-1] &&  pipe_pid[READ_LAT-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= 1'b0;
            pipe_vld <= '0;
            pipe_pid <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (grant0) begin
                rr_ptr <= 1'b1;
            end else if (grant1) begin
                rr_ptr <= 1'b0;
            end
            // Writes enter as bubbles; only reads produce a response.
            pipe_vld[0] <= rd_accept;
            pipe_pid[0] <= grant1;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_pid[i] <= pipe_pid[i-1];
            end
            if (resp0) begin
                rdata0_q <= bram_dout;
            end
            if (resp1) begin
                rdata1_q <= bram_dout;
            end
        end
    end

    // Response data passes straight from the BRAM in its valid cycle and
    // otherwise shows the last value delivered to that port.
    assign m0_resp_valid = resp0;
    assign m1_resp_valid = resp1;
    assign m0_resp_rdata = resp0 ? bram_dout : rdata0_q;
    assign m1_resp_rdata = resp1 ? bram_dout : rdata1_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
// Directed bench for bram_port_arbiter: one instance at READ_LAT=1 driven
// from a vector table plus a reset sequence, one at READ_LAT=2 for the
// registered-output timing. A behavioural no-change BRAM sits on each port.
module tb_bram_port_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // READ_LAT = 1 instance signals
    logic          m0_v, m0_we, m1_v, m1_we;
    logic [AW-1:0] m0_a, m1_a;
    logic [DW-1:0] m0_d, m1_d;
    logic          m0_rdy, m1_rdy, m0_rv, m1_rv;
    logic [DW-1:0] m0_rd, m1_rd;
    logic [AW-1:0] b1_addr;
    logic [DW-1:0] b1_din, b1_dout;
    logic          b1_we, b1_en, b1_regce, b1_rst;

    // READ_LAT = 2 instance signals
    logic          s0_v, s0_we, s1_v, s1_we;
    logic [AW-1:0] s0_a, s1_a;
    logic [DW-1:0] s0_d, s1_d;
    logic          s0_rdy, s1_rdy, s0_rv, s1_rv;
    logic [DW-1:0] s0_rd, s1_rd;
    logic [AW-1:0] b2_addr;
    logic [DW-1:0] b2_din, b2_dout, b2_lat;
    logic          b2_we, b2_en, b2_regce, b2_rst;

    logic [DW-1:0] mem [0:4095];

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1)) dut1 (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_v), .m0_req_we(m0_we), .m0_req_addr(m0_a),
        .m0_req_wdata(m0_d), .m0_req_ready(m0_rdy),
        .m0_resp_valid(m0_rv), .m0_resp_rdata(m0_rd),
        .m1_req_valid(m1_v), .m1_req_we(m1_we), .m1_req_addr(m1_a),
        .m1_req_wdata(m1_d), .m1_req_ready(m1_rdy),
        .m1_resp_valid(m1_rv), .m1_resp_rdata(m1_rd),
        .bram_addr(b1_addr), .bram_din(b1_din), .bram_we(b1_we),
        .bram_en(b1_en), .bram_regce(b1_regce), .bram_rst(b1_rst),
        .bram_dout(b1_dout)
    );

    bram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst),
        .m0_req_valid(s0_v), .m0_req_we(s0_we), .m0_req_addr(s0_a),
        .m0_req_wdata(s0_d), .m0_req_ready(s0_rdy),
        .m0_resp_valid(s0_rv), .m0_resp_rdata(s0_rd),
        .m1_req_valid(s1_v), .m1_req_we(s1_we), .m1_req_addr(s1_a),
        .m1_req_wdata(s1_d), .m1_req_ready(s1_rdy),
        .m1_resp_valid(s1_rv), .m1_resp_rdata(s1_rd),
        .bram_addr(b2_addr), .bram_din(b2_din), .bram_we(b2_we),
        .bram_en(b2_en), .bram_regce(b2_regce), .bram_rst(b2_rst),
        .bram_dout(b2_dout)
    );

    // No-change BRAM, latency 1: a write leaves dout untouched.
    always @(posedge clk) begin
        if (b1_en) begin
            if (b1_we) mem[b1_addr] <= b1_din;
            else       b1_dout <= mem[b1_addr];
        end
    end

    // Latency 2: array read latch followed by regce-gated output register.
    always @(posedge clk) begin
        if (b2_en && !b2_we) b2_lat <= mem[b2_addr];
        if (b2_regce)        b2_dout <= b2_lat;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic          v0, we0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1, we1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          rdy0, rdy1, rv0;
        logic [DW-1:0] rd0;
        logic          rv1;
        logic [DW-1:0] rd1;
        logic          en, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } vec_t;

    function automatic vec_t mk(
        input logic v0, we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
        input logic v1, we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
        input logic rdy0, rdy1, rv0, input logic [DW-1:0] rd0,
        input logic rv1, input logic [DW-1:0] rd1,
        input logic en, we, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        vec_t v;
        v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.rdy0 = rdy0; v.rdy1 = rdy1; v.rv0 = rv0; v.rd0 = rd0;
        v.rv1 = rv1; v.rd1 = rd1; v.en = en; v.we = we; v.addr = addr; v.din = din;
        return v;
    endfunction

    localparam logic [DW-1:0] D = 32'hDEADBEEF, C = 32'hCAFEF00D;
    localparam logic [DW-1:0] A = 32'h11111111, B = 32'h22222222;
    localparam logic [DW-1:0] N = 32'h12345678, P = 32'hA5A5A5A5;

    vec_t vecs [22];

    initial begin
        rst = 1'b1;
        {m0_v, m0_we, m0_a, m0_d, m1_v, m1_we, m1_a, m1_d} = '0;
        {s0_v, s0_we, s0_a, s0_d, s1_v, s1_we, s1_a, s1_d} = '0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        mem[12'h010] = D;
        mem[12'h001] = A;
        mem[12'h002] = B;
        mem[12'h7FF] = C;

        //            m0 req                 m1 req                 rdy0 rdy1 rv0 rd0 rv1 rd1  en we addr    din
        vecs[0]  = mk(0,0,12'h000,0,         0,0,12'h000,0,          0,0, 0,0, 0,0, 0,0,12'h000,0);
        vecs[1]  = mk(1,0,12'h010,0,         0,0,12'h000,0,          1,0, 0,0, 0,0, 1,0,12'h010,0);
        vecs[2]  = mk(0,0,12'h000,0,         0,0,12'h000,0,          0,0, 1,D, 0,0, 0,0,12'h000,0);
        vecs[3]  = mk(0,0,12'h000,0,         1,0,12'h7FF,0,          0,1, 0,D, 0,0, 1,0,12'h7FF,0);
        vecs[4]  = mk(0,0,12'h000,0,         0,0,12'h000,0,          0,0, 0,D, 1,C, 0,0,12'h000,0);
        vecs[5]  = mk(1,0,12'h001,0,         1,0,12'h002,0,          1,0, 0,D, 0,C, 1,0,12'h001,0);
        vecs[6]  = mk(1,0,12'h001,0,         1,0,12'h002,0,          0,1, 1,A, 0,C, 1,0,12'h002,0);
        vecs[7]  = mk(1,0,12'h001,0,         1,0,12'h002,0,          1,0, 0,A, 1,B, 1,0,12'h001,0);
        vecs[8]  = mk(1,0,12'h001,0,         1,0,12'h002,0,          0,1, 1,A, 0,B, 1,0,12'h002,0);
        vecs[9]  = mk(0,0,12'h000,0,         0,0,12'h000,0,          0,0, 0,A, 1,B, 0,0,12'h000,0);
        vecs[10] = mk(0,0,12'h000,0,         1,1,12'h0AB,N,          0,1, 0,A, 0,B, 1,1,12'h0AB,N);
        vecs[11] = mk(1,0,12'h0AB,0,         0,0,12'h000,0,          1,0, 0,A, 0,B, 1,0,12'h0AB,0);
        vecs[12] = mk(0,0,12'h000,0,         0,0,12'h000,0,          0,0, 1,N, 0,B, 0,0,12'h000,0);
        vecs[13] = mk(1,1,12'h0AB,P,         1,0,12'h0AB,0,          0,1, 0,N, 0,B, 1,0,12'h0AB,0);
        vecs[14] = mk(1,1,12'h0AB,P,         0,0,12'h000,0,          1,0, 0,N, 1,N, 1,1,12'h0AB,P);
        vecs[15] = mk(0,0,12'h000,0,         1,0,12'h0AB,0,          0,1, 0,N, 0,N, 1,0,12'h0AB,0);
        vecs[16] = mk(0,0,12'h000,0,         0,0,12'h000,0,          0,0, 0,N, 1,P, 0,0,12'h000,0);
        vecs[17] = mk(1,0,12'h010,0,         1,0,12'h001,0,          1,0, 0,N, 0,P, 1,0,12'h010,0);
        vecs[18] = mk(1,0,12'h010,0,         1,0,12'h001,0,          0,1, 1,D, 0,P, 1,0,12'h001,0);
        vecs[19] = mk(1,0,12'h010,0,         1,0,12'h001,0,          1,0, 0,D, 1,A, 1,0,12'h010,0);
        vecs[20] = mk(1,0,12'h010,0,         1,0,12'h001,0,          0,1, 1,D, 0,A, 1,0,12'h001,0);
        vecs[21] = mk(0,0,12'h000,0,         0,0,12'h000,0,          0,0, 0,D, 1,A, 0,0,12'h000,0);

        repeat (2) @(negedge clk);
        #2;
        chk("rst_ready0", m0_rdy, 0);
        chk("rst_en", b1_en, 0);
        chk("rst_bram_rst", b1_rst, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) begin
            m0_v = vecs[i].v0; m0_we = vecs[i].we0; m0_a = vecs[i].a0; m0_d = vecs[i].d0;
            m1_v = vecs[i].v1; m1_we = vecs[i].we1; m1_a = vecs[i].a1; m1_d = vecs[i].d1;
            #2;
            chk($sformatf("v%0d_rdy0", i), m0_rdy, vecs[i].rdy0);
            chk($sformatf("v%0d_rdy1", i), m1_rdy, vecs[i].rdy1);
            chk($sformatf("v%0d_rv0", i), m0_rv, vecs[i].rv0);
            chk($sformatf("v%0d_rd0", i), m0_rd, vecs[i].rd0);
            chk($sformatf("v%0d_rv1", i), m1_rv, vecs[i].rv1);
            chk($sformatf("v%0d_rd1", i), m1_rd, vecs[i].rd1);
            chk($sformatf("v%0d_en", i), b1_en, vecs[i].en);
            chk($sformatf("v%0d_we", i), b1_we, vecs[i].we);
            chk($sformatf("v%0d_addr", i), b1_addr, vecs[i].addr);
            chk($sformatf("v%0d_din", i), b1_din, vecs[i].din);
            chk($sformatf("v%0d_bram_rst", i), b1_rst, 0);
            @(negedge clk);
        end

        // Read accepted, then reset lands before its response cycle.
        // The accept leaves rr_ptr at 1, so m0 winning afterwards shows reset cleared it.
        m0_v = 1; m0_we = 0; m0_a = 12'h010; m1_v = 0;
        #2;
        chk("rr_accept_rdy0", m0_rdy, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rr_rst_rv0", m0_rv, 0);
        chk("rr_rst_rdy0", m0_rdy, 0);
        chk("rr_rst_en", b1_en, 0);
        chk("rr_rst_rd0", m0_rd, 0);
        chk("rr_rst_rd1", m1_rd, 0);
        chk("rr_rst_bram_rst", b1_rst, 1);
        @(negedge clk);
        chk("rr_rst_rv0_b", m0_rv, 0);
        @(negedge clk);
        rst = 1'b0;
        m0_v = 1; m0_a = 12'h001; m1_v = 1; m1_we = 0; m1_a = 12'h002;
        #2;
        chk("rr_post_rv0", m0_rv, 0);
        chk("rr_post_rdy0", m0_rdy, 1);
        chk("rr_post_rdy1", m1_rdy, 0);
        @(negedge clk);
        m0_v = 0; m1_v = 0;
        #2;
        chk("rr_post_rv0_b", m0_rv, 1);
        chk("rr_post_rd0", m0_rd, A);
        chk("rr_post_rv1", m1_rv, 0);
        @(negedge clk);

        // READ_LAT = 2 timing on the second instance.
        s1_v = 1; s1_we = 0; s1_a = 12'h7FF;
        #2;
        chk("l2_rdy1", s1_rdy, 1);
        chk("l2_regce_0", b2_regce, 0);
        chk("l2_rv1_0", s1_rv, 0);
        @(negedge clk);
        s1_v = 0;
        #2;
        chk("l2_regce_1", b2_regce, 1);
        chk("l2_rv1_1", s1_rv, 0);
        @(negedge clk);
        #2;
        chk("l2_regce_2", b2_regce, 0);
        chk("l2_rv1_2", s1_rv, 1);
        chk("l2_rd1_2", s1_rd, C);
        chk("l2_rv0_2", s0_rv, 0);
        @(negedge clk);
        #2;
        chk("l2_rv1_3", s1_rv, 0);
        chk("l2_rd1_3", s1_rd, C);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
